// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with a line-wide req/ack memory port.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int unsigned SETS      = 16,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned TAG_W     = 23
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned OFF_W  = $clog2(LINE_BITS / 8);
  localparam int unsigned WSEL_W = OFF_W - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e                    state_q, state_d;
  logic [SETS-1:0]           valid_q, dirty_q;
  logic [TAG_W-1:0]          tag_q  [SETS];
  logic [LINE_BITS-1:0]      data_q [SETS];
  logic [TAG_W+IDX_W-1:0]    miss_q, miss_d;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_wsel;
  logic [IDX_W-1:0]  miss_idx;
  logic [TAG_W-1:0]  miss_tag;
  logic              hit, idle_hit, store_hit, fill;
  logic              unused_addr_bits;

  assign req_tag          = cpu_addr_i[31 -: TAG_W];
  assign req_idx          = cpu_addr_i[OFF_W +: IDX_W];
  assign req_wsel         = cpu_addr_i[2 +: WSEL_W];
  assign miss_idx         = miss_q[IDX_W-1:0];
  assign miss_tag         = miss_q[IDX_W +: TAG_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign idle_hit = (state_q == IDLE) && cpu_req_i && hit;

  always_comb begin
    state_d     = state_q;
    miss_d      = miss_q;
    cpu_data_o  = '0;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_data_o  = '0;
    store_hit   = 1'b0;
    fill        = 1'b0;
    // All outputs and write strobes are held quiet while reset is asserted.
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req_i) begin
            if (hit) begin
              store_hit = cpu_we_i;
              if (!cpu_we_i) cpu_data_o = data_q[req_idx][{req_wsel, 5'b0} +: 32];
            end else begin
              cpu_stall_o = 1'b1;
              miss_d      = cpu_addr_i[31:OFF_W];
              state_d     = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          cpu_stall_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = {tag_q[miss_idx], miss_idx, {OFF_W{1'b0}}};
          mem_data_o  = data_q[miss_idx];
          if (mem_ack_i) state_d = ALLOCATE;
        end
        ALLOCATE: begin
          cpu_stall_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_addr_o  = {miss_q, {OFF_W{1'b0}}};
          if (mem_ack_i) begin
            fill    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      if (fill) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[req_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays need no reset; valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= mem_data_i;
    end else if (store_hit) begin
      data_q[req_idx][{req_wsel, 5'b0} +: 32] <= cpu_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refill_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // refill_q masks the re-evaluated hit that completes a miss.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      refill_q <= fill;
      if (idle_hit && !refill_q) hit_cnt_q <= hit_cnt_q + 32'd1;
      if ((state_q == IDLE) && (state_d != IDLE)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  logic unused_idle_hit;
  assign unused_idle_hit = idle_hit;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl; counter checks are compiled in with DCACHE_STATS_EN.
module tb_dcache_ctrl;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_we_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int stall_total = 0;
  int stall_base;

  logic [255:0] line1, line2, line3;

  dcache_ctrl #(.SETS(16), .LINE_BITS(256), .TAG_W(23)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cpu_req_i  (cpu_req_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .cpu_stall_o(cpu_stall_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_ack_i  (mem_ack_i)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (cpu_stall_o === 1'b1) stall_total++;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+2 with the request already presented; acks in its n-th cycle.
  task automatic mem_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [255:0] rdata, input int n);
    chk({tag, "_req"}, mem_req_o, 1'b1);
    chk({tag, "_we"}, mem_we_o, we);
    chk({tag, "_addr"}, mem_addr_o, addr);
    chk({tag, "_stall"}, cpu_stall_o, 1'b1);
    for (int i = 1; i < n; i++) begin
      cyc();
      #1;
    end
    mem_ack_i  = 1'b1;
    mem_data_i = rdata;
    cyc();
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    #1;
  endtask

  initial begin
    line1 = '0; line1[31:0] = 32'h1111_0000; line1[63:32] = 32'hDEAD_BEEF;
    line2 = '0; line2[31:0] = 32'hA5A5_0240;
    line3 = '0; line3[31:0] = 32'h3333_3333;

    rst_i = 1'b1; cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h40;
    cpu_data_i = '0; mem_ack_i = 1'b0; mem_data_i = '0;
    cyc(); cyc(); #1;
    chk("rst_stall", cpu_stall_o, 1'b0);
    chk("rst_mreq", mem_req_o, 1'b0);
    chk("rst_maddr", mem_addr_o, 32'h0);
    chk("rst_data", cpu_data_o, 32'h0);

    // Cold load miss on 0x40, 3-cycle fill
    cyc(); rst_i = 1'b0; stall_base = stall_total; #1;
    chk("miss1_stall", cpu_stall_o, 1'b1);
    chk("miss1_idle_mreq", mem_req_o, 1'b0);
    cyc(); #1;
    mem_txn("fill1", 1'b0, 32'h40, line1, 3);
    chk("fill1_hit_stall", cpu_stall_o, 1'b0);
    chk("fill1_word0", cpu_data_o, 32'h1111_0000);
    chk("fill1_penalty", stall_total - stall_base, 4);
    cpu_addr_i = 32'h44; #1;
    chk("load44", cpu_data_o, 32'hDEAD_BEEF);
    chk("load44_stall", cpu_stall_o, 1'b0);

    // Store hit then load back
    cyc(); cpu_we_i = 1'b1; cpu_addr_i = 32'h40; cpu_data_i = 32'h1234_5678; #1;
    chk("store_stall", cpu_stall_o, 1'b0);
    chk("store_data_o", cpu_data_o, 32'h0);
    cyc(); cpu_we_i = 1'b0; #1;
    chk("load40", cpu_data_o, 32'h1234_5678);

    // Conflict miss on dirty index 2
    cyc(); cpu_addr_i = 32'h240; stall_base = stall_total; #1;
    chk("miss2_stall", cpu_stall_o, 1'b1);
    cyc(); #1;
    chk("wb_line", mem_data_o[63:0], 64'hDEAD_BEEF_1234_5678);
    mem_txn("wb", 1'b1, 32'h40, '0, 3);
    mem_txn("fill2", 1'b0, 32'h240, line2, 3);
    chk("fill2_stall", cpu_stall_o, 1'b0);
    chk("fill2_word0", cpu_data_o, 32'hA5A5_0240);
    chk("dirty_penalty", stall_total - stall_base, 7);

    // Clean miss on index 3
    cyc(); cpu_addr_i = 32'h60; stall_base = stall_total; #1;
    chk("miss3_stall", cpu_stall_o, 1'b1);
    cyc(); #1;
    mem_txn("fill3", 1'b0, 32'h60, line3, 2);
    chk("fill3_word0", cpu_data_o, 32'h3333_3333);
    chk("clean_penalty", stall_total - stall_base, 3);
    cpu_addr_i = 32'h240; #1;
    chk("idx2_kept", cpu_data_o, 32'hA5A5_0240);

    // Reset in the middle of ALLOCATE
    cyc(); cpu_addr_i = 32'h80; #1;
    chk("miss4_stall", cpu_stall_o, 1'b1);
    cyc(); #1;
    chk("alloc4_addr", mem_addr_o, 32'h80);
    cyc(); rst_i = 1'b1; #1;
    chk("rst_alloc_mreq", mem_req_o, 1'b0);
    cyc(); rst_i = 1'b0; cpu_req_i = 1'b0; #1;
    chk("post_rst_mreq", mem_req_o, 1'b0);
    chk("post_rst_stall", cpu_stall_o, 1'b0);
    mem_ack_i = 1'b1; mem_data_i = line2;
    cyc(); mem_ack_i = 1'b0; mem_data_i = '0; #1;
    chk("late_ack_mreq", mem_req_o, 1'b0);
    chk("late_ack_stall", cpu_stall_o, 1'b0);
    cpu_req_i = 1'b1; cpu_addr_i = 32'h40; #1;
    chk("post_rst_miss", cpu_stall_o, 1'b1);
    cyc(); #1;
    mem_txn("fill5", 1'b0, 32'h40, line1, 1);
    chk("fill5_word0", cpu_data_o, 32'h1111_0000);

`ifdef DCACHE_STATS_EN
    cyc(); rst_i = 1'b1; cpu_req_i = 1'b0;
    cyc(); rst_i = 1'b0; #1;
    chk("cnt_rst_hit", hit_cnt, 32'd0);
    chk("cnt_rst_miss", miss_cnt, 32'd0);
    cyc(); cpu_req_i = 1'b1; cpu_addr_i = 32'h40; cpu_we_i = 1'b0; #1;
    cyc(); #1;
    mem_txn("sfill1", 1'b0, 32'h40, line1, 1);
    cpu_req_i = 1'b0;
    cyc(); cpu_req_i = 1'b1; cpu_addr_i = 32'h40;
    cyc(); cpu_we_i = 1'b1; cpu_addr_i = 32'h44; cpu_data_i = 32'hCAFE_F00D;
    cyc(); cpu_we_i = 1'b0;
    cyc(); cpu_addr_i = 32'hA0; #1;
    cyc(); #1;
    mem_txn("sfill2", 1'b0, 32'hA0, line3, 1);
    cpu_req_i = 1'b0;
    cyc(); #1;
    chk("cnt_hit", hit_cnt, 32'd3);
    chk("cnt_miss", miss_cnt, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
